tick_gen: RTL

TICK_GEN -- requirements
Module: tick_gen

---
 rtl/tick_pkg.sv | 13 +
 rtl/tick_chan.sv | 70 +++++++
 rtl/tick_gen.sv | 73 +++++++
 3 files changed

// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator: channel FSM states
// and the channel mode encoding.
package tick_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: shadow period/mode, IDLE/RUN FSM and a
// base-tick down-counter producing a registered tic pulse.
module tick_chan
    import tick_pkg::*;
#(
    parameter int PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          base_tic,
    input  logic          wr,
    input  logic [PW-1:0] wr_period,
    input  logic          wr_mode,
    input  logic          start,
    input  logic          stop,
    output logic          tic,
    output logic          busy
);

    chan_state_t   state;
    logic [PW-1:0] period;
    logic          mode;
    logic [PW-1:0] count;
    logic [PW-1:0] period_eff;
    logic          mode_eff;

    // A write in the same cycle as a start/reload is already visible.
    assign period_eff = wr ? wr_period : period;
    assign mode_eff   = wr ? wr_mode : mode;

    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            period <= '0;
            mode   <= MODE_PERIODIC;
            count  <= '0;
            tic    <= 1'b0;
        end else begin
            tic <= 1'b0;
            if (wr) begin
                period <= wr_period;
                mode   <= wr_mode;
            end
            if (stop) begin
                state <= IDLE;
                count <= '0;
            end else if (start) begin
                if (period_eff != '0) begin
                    state <= RUN;
                    count <= period_eff;
                end
            end else if (state == RUN && base_tic) begin
                if (count == PW'(1)) begin
                    tic <= 1'b1;
                    if (mode_eff == MODE_ONESHOT) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        count <= period_eff;
                    end
                end else begin
                    count <= count - PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Base-tick prescaler, channel config decode and NCH
// independent tick channels.
module tick_gen
    import tick_pkg::*;
#(
    parameter int PRESCALE = 100_000,
    parameter int PW       = 16,
    parameter int NCH      = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic                               cfg_we,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
    input  logic [PW-1:0]                      cfg_period,
    input  logic                               cfg_mode,
    input  logic [NCH-1:0]                     start,
    input  logic [NCH-1:0]                     stop,
    output logic                               base_tic,
    output logic [NCH-1:0]                     tic,
    output logic [NCH-1:0]                     busy
);

    localparam int SW = $clog2(PRESCALE);
    localparam logic [SW-1:0] LAST = SW'(PRESCALE - 1);

    logic [SW-1:0]  pcnt;
    logic [NCH-1:0] wr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt     <= '0;
            base_tic <= 1'b0;
        end else begin
            base_tic <= 1'b0;
            if (en) begin
                if (pcnt == LAST) begin
                    pcnt     <= '0;
                    base_tic <= 1'b1;
                end else begin
                    pcnt <= pcnt + SW'(1);
                end
            end
        end
    end

    // Out-of-range channel numbers match no bit and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cfg_we && (32'(cfg_ch) == i))
                wr_sel[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        tick_chan #(
            .PW(PW)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .base_tic (base_tic),
            .wr       (wr_sel[g]),
            .wr_period(cfg_period),
            .wr_mode  (cfg_mode),
            .start    (start[g]),
            .stop     (stop[g]),
            .tic      (tic[g]),
            .busy     (busy[g])
        );
    end

endmodule
